// File: rtl/error_inject_ctrl_pkg.sv
// Shared types and constants for the bit-flip error-injection controller.
// Holds the FSM state encoding, the mode codes and the flipped bit positions.
package err_inj_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam logic [1:0] MODE_SINGLE   = 2'b00;
  localparam logic [1:0] MODE_BURST    = 2'b01;
  localparam logic [1:0] MODE_PERIODIC = 2'b10;
  localparam logic [1:0] MODE_RSVD     = 2'b11;

  localparam int FLIP_BIT1 = 0;
  localparam int FLIP_BIT2 = 4;

endpackage

// File: rtl/error_inject_ctrl_if.sv
// Word-stream and status bundle between the data-path sequencer (master)
// and the error-injection controller (slave).
interface error_inject_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic             word_stb;
  logic [1:0]       mode;
  logic [CNT_W-1:0] burst_len;
  logic [CNT_W-1:0] period;
  logic [WIDTH-1:0] flip_mask;
  logic             inject;
  logic             busy;
  logic [CNT_W-1:0] inj_count;

  modport master (
    output word_stb, mode, burst_len, period,
    input  flip_mask, inject, busy, inj_count
  );

  modport slave (
    input  word_stb, mode, burst_len, period,
    output flip_mask, inject, busy, inj_count
  );

endinterface

// File: rtl/error_inject_ctrl_btn_sync_edge.sv
// Synchronizes one raw button and emits a registered one-cycle pulse on
// each rising edge of the synchronized level.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   pulse_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg[0] <= 1'b0;
    end else begin
      sync_reg[0] <= btn;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // Registering the pulse keeps the FSM input free of the synchronizer path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      prev_reg  <= sync_reg[SYNC_STAGES-1];
      pulse_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/error_inject_ctrl.sv
// Error-injection sequencer: turns button edges into a flip mask and applies
// it to strobed data words in single, burst or periodic mode.
module error_inject_ctrl
  import err_inj_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn1,
  input  logic btn2,
  error_inject_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic e1;
  logic e2;
  logic arm_evt;

  state_t           state_reg,     state_next;
  logic [WIDTH-1:0] mask_reg,      mask_next;
  logic [1:0]       mode_reg,      mode_next;
  logic [CNT_W-1:0] period_reg,    period_next;
  logic [CNT_W-1:0] gap_reg,       gap_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [CNT_W-1:0] count_reg,     count_next;
  logic             hit;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .clk   (clk),
    .rst   (rstn),
    .btn   (btn1),
    .pulse (e1)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (
    .clk   (clk),
    .rst   (rstn),
    .btn   (btn2),
    .pulse (e2)
  );

  assign arm_evt = e1 | e2;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_reg     <= IDLE;
      mask_reg      <= '0;
      mode_reg      <= MODE_SINGLE;
      period_reg    <= '0;
      gap_reg       <= '0;
      remaining_reg <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      mode_reg      <= mode_next;
      period_reg    <= period_next;
      gap_reg       <= gap_next;
      remaining_reg <= remaining_next;
      count_reg     <= count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mask_next      = mask_reg;
    mode_next      = mode_reg;
    period_next    = period_reg;
    gap_next       = gap_reg;
    remaining_next = remaining_reg;
    hit            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (arm_evt) begin
          state_next            = ARMED;
          mask_next             = '0;
          mask_next[FLIP_BIT1]  = e1;
          mask_next[FLIP_BIT2]  = e2;
          mode_next             = bus.mode;
          period_next           = (bus.period == '0) ? ONE : bus.period;
          gap_next              = '0;
          if (bus.mode == MODE_BURST) begin
            remaining_next = (bus.burst_len == '0) ? ONE : bus.burst_len;
          end else begin
            remaining_next = ONE;
          end
        end
      end

      ARMED: begin
        // A cancelling edge beats a coincident qualifying strobe.
        if ((mode_reg == MODE_PERIODIC) && arm_evt) begin
          state_next = IDLE;
          mask_next  = '0;
        end else if (bus.word_stb) begin
          if (gap_reg == '0) begin
            hit = 1'b1;
            if (mode_reg == MODE_PERIODIC) begin
              gap_next = period_reg - ONE;
            end else begin
              remaining_next = remaining_reg - ONE;
              if (remaining_reg == ONE) begin
                state_next = IDLE;
                mask_next  = '0;
              end
            end
          end else begin
            gap_next = gap_reg - ONE;
          end
        end
      end

      default: begin
        state_next = IDLE;
        mask_next  = '0;
      end
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (hit && (count_reg != {CNT_W{1'b1}})) begin
      count_next = count_reg + ONE;
    end
  end

  assign bus.flip_mask = hit ? mask_reg : '0;
  assign bus.inject    = |bus.flip_mask;
  assign bus.busy      = (state_reg == ARMED);
  assign bus.inj_count = count_reg;

endmodule

// File: tb/tb_error_inject_ctrl.sv
// Directed bench for error_inject_ctrl: a CNT_W=8 instance for the main modes
// and a CNT_W=2 instance for counter saturation.
module tb_error_inject_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic btn1, btn2;
  logic sb1, sb2;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  error_inject_ctrl_if #(.WIDTH(8), .CNT_W(8)) bus ();
  error_inject_ctrl_if #(.WIDTH(8), .CNT_W(2)) bus_s ();

  error_inject_ctrl #(.WIDTH(8), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .btn1 (btn1),
    .btn2 (btn2),
    .bus  (bus)
  );

  error_inject_ctrl #(.WIDTH(8), .CNT_W(2), .SYNC_STAGES(2)) dut_sat (
    .clk  (clk),
    .rstn (rstn),
    .btn1 (sb1),
    .btn2 (sb2),
    .bus  (bus_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; presses the selected buttons, checks busy just before
  // and just after the edge at which the FSM should see the pulse, releases.
  task automatic press(input logic [1:0] b, input logic sat,
                       input logic exp_pre, input logic exp_post, input string tag);
    if (sat) begin sb1 = b[0]; sb2 = b[1]; end
    else     begin btn1 = b[0]; btn2 = b[1]; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_busy_pre"}, sat ? bus_s.busy : bus.busy, exp_pre);
    @(posedge clk); #1;
    check({tag, "_busy_post"}, sat ? bus_s.busy : bus.busy, exp_post);
    $display("press %s btn=%b busy=%b", tag, b, sat ? bus_s.busy : bus.busy);
    btn1 = 1'b0; btn2 = 1'b0; sb1 = 1'b0; sb2 = 1'b0;
  endtask

  // Called at posedge+1; one strobe cycle, returns at the next posedge+1.
  task automatic strobe(input logic sat, input logic [7:0] exp_mask, input string tag);
    logic [7:0] m;
    logic       inj;
    if (sat) bus_s.word_stb = 1'b1; else bus.word_stb = 1'b1;
    @(negedge clk);
    m   = sat ? bus_s.flip_mask : bus.flip_mask;
    inj = sat ? bus_s.inject : bus.inject;
    check({tag, "_mask"}, m, exp_mask);
    check({tag, "_inject"}, inj, exp_mask != 8'h00);
    $display("strobe %s mask=%h inject=%b", tag, m, inj);
    @(posedge clk); #1;
    bus.word_stb = 1'b0; bus_s.word_stb = 1'b0;
  endtask

  initial begin
    rstn = 1'b1;
    btn1 = 1'b0; btn2 = 1'b0; sb1 = 1'b0; sb2 = 1'b0;
    bus.word_stb = 1'b0; bus.mode = 2'b00; bus.burst_len = 8'd0; bus.period = 8'd0;
    bus_s.word_stb = 1'b0; bus_s.mode = 2'b10; bus_s.burst_len = 2'd0; bus_s.period = 2'd1;
    repeat (3) @(posedge clk); #1;
    check("rst_mask", bus.flip_mask, 8'h00);
    check("rst_inject", bus.inject, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_count", bus.inj_count, 8'd0);
    rstn = 1'b0;
    @(posedge clk); #1;

    // Single shot with btn1
    bus.mode = 2'b00;
    press(2'b01, 1'b0, 1'b0, 1'b1, "single");
    strobe(1'b0, 8'h01, "single_s1");
    check("single_busy", bus.busy, 1'b0);
    strobe(1'b0, 8'h00, "single_s2");
    strobe(1'b0, 8'h00, "single_s3");
    check("single_count", bus.inj_count, 8'd1);

    // Burst of 3 with both buttons; a btn2 edge while armed is ignored
    bus.mode = 2'b01; bus.burst_len = 8'd3;
    press(2'b11, 1'b0, 1'b0, 1'b1, "burst");
    strobe(1'b0, 8'h11, "burst_s1");
    press(2'b10, 1'b0, 1'b1, 1'b1, "burst_ignore");
    strobe(1'b0, 8'h11, "burst_s2");
    strobe(1'b0, 8'h11, "burst_s3");
    strobe(1'b0, 8'h00, "burst_s4");
    strobe(1'b0, 8'h00, "burst_s5");
    check("burst_busy", bus.busy, 1'b0);
    check("burst_count", bus.inj_count, 8'd4);

    // Periodic every 3 with btn2; live mode/period edits are ignored
    bus.mode = 2'b10; bus.period = 8'd3;
    press(2'b10, 1'b0, 1'b0, 1'b1, "per");
    strobe(1'b0, 8'h10, "per_s1");
    strobe(1'b0, 8'h00, "per_s2");
    bus.mode = 2'b00; bus.period = 8'd1;
    strobe(1'b0, 8'h00, "per_s3");
    strobe(1'b0, 8'h10, "per_s4");
    strobe(1'b0, 8'h00, "per_s5");
    strobe(1'b0, 8'h00, "per_s6");
    strobe(1'b0, 8'h10, "per_s7");
    strobe(1'b0, 8'h00, "per_s8");
    strobe(1'b0, 8'h00, "per_s9");
    check("per_count", bus.inj_count, 8'd7);
    // btn1 edge pulse lands exactly on strobe 10
    btn1 = 1'b1;
    repeat (3) @(posedge clk); #1;
    strobe(1'b0, 8'h00, "per_cancel_s10");
    btn1 = 1'b0;
    check("per_cancel_busy", bus.busy, 1'b0);
    check("per_cancel_count", bus.inj_count, 8'd7);
    repeat (3) @(posedge clk); #1;

    // Zero burst_len and zero period act as 1
    bus.mode = 2'b01; bus.burst_len = 8'd0;
    press(2'b01, 1'b0, 1'b0, 1'b1, "zburst");
    strobe(1'b0, 8'h01, "zburst_s1");
    check("zburst_busy", bus.busy, 1'b0);
    strobe(1'b0, 8'h00, "zburst_s2");
    bus.mode = 2'b10; bus.period = 8'd0;
    press(2'b10, 1'b0, 1'b0, 1'b1, "zper");
    strobe(1'b0, 8'h10, "zper_s1");
    strobe(1'b0, 8'h10, "zper_s2");
    strobe(1'b0, 8'h10, "zper_s3");
    press(2'b01, 1'b0, 1'b1, 1'b0, "zper_cancel");
    check("zper_count", bus.inj_count, 8'd11);

    // Saturation on the CNT_W=2 instance
    press(2'b01, 1'b1, 1'b0, 1'b1, "sat");
    for (int i = 0; i < 5; i++) strobe(1'b1, 8'h01, $sformatf("sat_s%0d", i + 1));
    check("sat_count", bus_s.inj_count, 32'd3);

    // Asynchronous reset in the middle of a burst
    bus.mode = 2'b01; bus.burst_len = 8'd4;
    press(2'b01, 1'b0, 1'b0, 1'b1, "rstb");
    strobe(1'b0, 8'h01, "rstb_s1");
    bus.word_stb = 1'b1;
    #1;
    check("rstb_pre_mask", bus.flip_mask, 8'h01);
    #1 rstn = 1'b1;
    #1;
    check("rstb_mask", bus.flip_mask, 8'h00);
    check("rstb_busy", bus.busy, 1'b0);
    check("rstb_count", bus.inj_count, 8'd0);
    check("rstb_sat_count", bus_s.inj_count, 32'd0);
    @(posedge clk); #1;
    bus.word_stb = 1'b0;
    rstn = 1'b0;
    strobe(1'b0, 8'h00, "rstb_after1");
    strobe(1'b0, 8'h00, "rstb_after2");
    check("rstb_after_count", bus.inj_count, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/error_inject_ctrl.md
# error_inject_ctrl

Sequencing controller for the bit-flip error-injection datapath. It converts raw button presses into a registered flip mask (bit 0 for btn1, bit 4 for btn2) and applies that mask to a stream of data words. Injection runs in one of three modes: single-shot, burst of N words, or periodic every P words. It sits between the board buttons and the XOR stage that corrupts the data bus, and reports busy status and a running injection count for display logic.

## Interface
Parameters:
- WIDTH, 8, data/mask width; must be ≥ 5.
- CNT_W, 8, width of burst_len, period, internal counters and inj_count.
- SYNC_STAGES, 2, synchronizer flops per button; ≥ 2.

Ports:
- clk  in  1  single system clock, rising edge.
- rstn  in  1  reset, asynchronous, active-high despite the name; asserted = 1.
- btn1  in  1  raw asynchronous button; rising edge arms a flip of bit 0.
- btn2  in  1  raw asynchronous button; rising edge arms a flip of bit 4.
- word_stb  in  1  one-cycle strobe marking a valid data word on the bus this cycle.
- mode  in  2  00 single, 01 burst, 10 periodic, 11 reserved (behaves as single).
- burst_len  in  CNT_W  words to corrupt in burst mode; 0 treated as 1.
- period  in  CNT_W  word spacing in periodic mode; 0 treated as 1.
- flip_mask  out  WIDTH  XOR mask for the current word; all-zero when not injecting.
- inject  out  1  high exactly when flip_mask is non-zero.
- busy  out  1  high in state ARMED.
- inj_count  out  CNT_W  total corrupted words since reset, saturates at all-ones.

## Operation
- Each button passes through a SYNC_STAGES synchronizer and a rising-edge detector, giving one-cycle pulses e1 and e2.
- FSM has two states.
  - IDLE: on e1|e2, go to ARMED. Latch mask = {bit0 = e1, bit4 = e2}. Sample mode, burst_len and period. Set gap = 0 and remaining = eff_burst (burst mode) or 1 (single/reserved).
  - ARMED: on word_stb with gap == 0, inject.
    - Periodic: set gap = eff_period − 1.
    - Other modes: decrement remaining; return to IDLE when it reaches 0.
  - ARMED: on word_stb with gap != 0, decrement gap; no injection.
  - Periodic mode never self-terminates. Any e1|e2 in ARMED+periodic cancels and returns to IDLE.
- Other modes ignore button edges while ARMED; no re-arm and no mask change.
- mode, burst_len and period changes while ARMED have no effect until the next arm.
- Simultaneous e1 and e2 in IDLE: mask has both bits 0 and 4 set.
- Cancel coincident with an injecting word_stb: cancel wins, flip_mask = 0 that cycle, inj_count unchanged.
- inj_count increments by 1 on each cycle with inject = 1 and holds at 2^CNT_W − 1.

## Timing
- Reset values: state IDLE, mask 0, counters 0, flip_mask 0, inject 0, busy 0, inj_count 0, synchronizers 0.
- Edge latency: with SYNC_STAGES = 2 and btn first sampled high at clock edge k, e pulses during cycle k+2→k+3 and busy is high from edge k+3.
- Injection is zero-latency to the strobe. flip_mask = mask and inject = 1 combinationally in the same cycle as the qualifying word_stb, gated by registered state and gap.
- word_stb in the same cycle as the arming edge pulse is not injected. The first eligible word is the next strobe.
- Back-to-back strobes are legal, one word per cycle. Burst of N consecutive strobes gives N consecutive inject cycles.
- Periodic, period P: the 1st, (P+1)th, (2P+1)th … strobes after arming are corrupted.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous). No partial injection after release.
- Buttons held high generate a single edge; re-arming requires release and re-press.

## Structure
- Package err_inj_pkg holds:
  - state enum {IDLE, ARMED};
  - mode constants MODE_SINGLE, MODE_BURST, MODE_PERIODIC, MODE_RSVD;
  - bit-position constants FLIP_BIT1 = 0, FLIP_BIT2 = 4.
- Sub-module btn_sync_edge (synchronizer plus rising-edge detector, parameter SYNC_STAGES), instantiated once per button.
- Controller top holds the FSM, gap/remaining counters, mask register and saturating inj_count.

## Test plan
- Single: mode 00, press btn1, then 3 strobes → only first strobe has flip_mask 0x01; busy falls after it; inj_count = 1.
- Both buttons same cycle, burst_len 3: mode 01, then 5 strobes → strobes 1–3 show flip_mask 0x11, strobes 4–5 show 0x00; inj_count = 3.
- Periodic: mode 10, period 3, btn2, 8 strobes → strobes 1, 4, 7 show 0x10; a btn1 press coincident with strobe 10 cancels with mask 0 and busy low.
- Zero parameters: burst_len 0 or period 0 → behaves as 1; burst injects one word, periodic corrupts every strobe.
- Saturation and reset: CNT_W = 2, periodic with period 1, 5 strobes → inj_count holds at 3. Assert rstn mid-burst → flip_mask, busy and inj_count read 0 immediately; subsequent strobes are not corrupted.
